// File: rtl/disp_scan_if.sv
// Bundles the operand/result inputs and the multiplexed display outputs of disp_scan.
interface disp_scan_if;
   logic        selout;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic [15:0] result;
   logic        res_valid;
   logic [7:0]  seg_n;
   logic [3:0]  an_n;

   // Source of the values to display; sink of the display drive.
   modport master (
      output selout, op_a, op_b, result, res_valid,
      input  seg_n, an_n
   );

   // The display scanner itself.
   modport slave (
      input  selout, op_a, op_b, result, res_valid,
      output seg_n, an_n
   );
endinterface

// File: rtl/disp_scan.sv
// Four-digit multiplexed active-low 7-segment scanner showing A|B or the 16-bit result.
// A per-frame shadow copy of the inputs keeps a frame tear-free. The first BLANK cycles
// of each digit slot turn all anodes off to avoid ghosting between digits.
module disp_scan #(
   parameter int PRESCALE = 16384,
   parameter int BLANK    = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   disp_scan_if.slave  bus
);
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_W  = CW'(BLANK);

   logic [CW-1:0] cnt_reg;
   logic [1:0]    dig_reg;
   logic          sh_sel_reg;
   logic          sh_valid_reg;
   logic [15:0]   sh_ab_reg;
   logic [15:0]   sh_res_reg;
   logic [3:0]    an_reg, an_next;
   logic [7:0]    seg_reg, seg_next;

   logic          tick;
   logic          frame_end;
   logic          blank;
   logic [3:0]    nib [4];

   assign tick      = (cnt_reg == CNT_LAST);
   assign frame_end = tick && (dig_reg == 2'd3);
   assign blank     = (cnt_reg < BLANK_W);

   // Hex digit to active-low segments {dp,g,f,e,d,c,b,a}, dp off.
   function automatic logic [7:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: hex7 = 8'hC0;
         4'h1: hex7 = 8'hF9;
         4'h2: hex7 = 8'hA4;
         4'h3: hex7 = 8'hB0;
         4'h4: hex7 = 8'h99;
         4'h5: hex7 = 8'h92;
         4'h6: hex7 = 8'h82;
         4'h7: hex7 = 8'hF8;
         4'h8: hex7 = 8'h80;
         4'h9: hex7 = 8'h90;
         4'hA: hex7 = 8'h88;
         4'hB: hex7 = 8'h83;
         4'hC: hex7 = 8'hC6;
         4'hD: hex7 = 8'hA1;
         4'hE: hex7 = 8'h86;
         default: hex7 = 8'h8E;
      endcase
   endfunction

   // {A,B} packed as one word lines up A[7:4] with digit 3 down to B[3:0] on digit 0.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         assign nib[gi] = sh_sel_reg ? sh_ab_reg[4*gi +: 4] : sh_res_reg[4*gi +: 4];
      end
   endgenerate

   // Refresh prescaler and digit scan counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
         dig_reg <= 2'd0;
      end else begin
         cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
         if (tick) dig_reg <= dig_reg + 2'd1;
      end
   end

   // Shadow copy of the display inputs, refreshed only at the end of digit 3's slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_sel_reg   <= 1'b0;
         sh_valid_reg <= 1'b0;
         sh_ab_reg    <= '0;
         sh_res_reg   <= '0;
      end else if (frame_end) begin
         sh_sel_reg   <= bus.selout;
         sh_valid_reg <= bus.res_valid;
         sh_ab_reg    <= {bus.op_a, bus.op_b};
         sh_res_reg   <= bus.result;
      end
   end

   // Anode and segment pattern for the current counter state and shadow contents.
   always_comb begin
      an_next  = 4'hF;
      seg_next = 8'hFF;
      if (!blank) begin
         an_next = ~(4'b0001 << dig_reg);
         if (!sh_sel_reg && !sh_valid_reg)
            seg_next = 8'hBF;
         else if (sh_sel_reg && dig_reg == 2'd2)
            seg_next = hex7(nib[dig_reg]) & 8'h7F;
         else
            seg_next = hex7(nib[dig_reg]);
      end
   end

   // Registered display drive, one clock behind the scan state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_reg  <= 4'hF;
         seg_reg <= 8'hFF;
      end else begin
         an_reg  <= an_next;
         seg_reg <= seg_next;
      end
   end

   assign bus.an_n  = an_reg;
   assign bus.seg_n = seg_reg;
endmodule

// File: tb/tb_disp_scan.sv
// Randomized bench for disp_scan with a frame-level reference model (PRESCALE=8, BLANK=2).
module tb_disp_scan;
   localparam int PS  = 8;
   localparam int BL  = 2;
   localparam int PER = 4 * PS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic chk_en = 1'b1;

   disp_scan_if bus ();

   disp_scan #(.PRESCALE(PS), .BLANK(BL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Segment table for hex digits, dp off.
   logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model state: edges since reset release and the values latched for the frame on show.
   int          k = 0;
   logic        m_sel = 1'b0, m_valid = 1'b0;
   logic [7:0]  m_a = '0, m_b = '0;
   logic [15:0] m_res = '0;
   logic [3:0]  exp_an = 4'hF;
   logic [7:0]  exp_seg = 8'hFF;

   function automatic logic [3:0] model_an(input int t);
      int slot_pos = t % PS;
      int d = (t / PS) % 4;
      if (slot_pos < BL) return 4'hF;
      return ~(4'(1) << d);
   endfunction

   function automatic logic [7:0] model_seg(input int t, input logic s, input logic v,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic [15:0] r);
      int slot_pos = t % PS;
      int d = (t / PS) % 4;
      int nibv;
      if (slot_pos < BL) return 8'hFF;
      if (!s && !v) return 8'hBF;
      if (s) begin
         case (d)
            3: nibv = int'(a) / 16;
            2: nibv = int'(a) % 16;
            1: nibv = int'(b) / 16;
            default: nibv = int'(b) % 16;
         endcase
         return (d == 2) ? (hex_tbl[nibv] & 8'h7F) : hex_tbl[nibv];
      end
      nibv = (int'(r) >> (4 * d)) % 16;
      return hex_tbl[nibv];
   endfunction

   // Reference model: output after each edge follows the scan position before it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k <= 0;
         m_sel <= 1'b0; m_valid <= 1'b0; m_a <= '0; m_b <= '0; m_res <= '0;
         exp_an <= 4'hF; exp_seg <= 8'hFF;
      end else begin
         exp_an  <= model_an(k);
         exp_seg <= model_seg(k, m_sel, m_valid, m_a, m_b, m_res);
         if (k % PER == PER - 1) begin
            m_sel <= bus.selout; m_valid <= bus.res_valid;
            m_a <= bus.op_a; m_b <= bus.op_b; m_res <= bus.result;
         end
         k <= k + 1;
      end
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Every cycle: outputs against the model, and never two anodes on together.
   always @(negedge clk) begin
      if (chk_en) begin
         check("an_n", 16'(bus.an_n), 16'(exp_an));
         check("seg_n", 16'(bus.seg_n), 16'(exp_seg));
         check("one_hot", 16'($countones(~bus.an_n) <= 1), 16'd1);
      end
   end

   // Advance to the negedge where the scan phase within a frame equals p.
   task automatic wait_phase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((k % PER) != p && n < 3 * PER);
      if (n >= 3 * PER) check("wait_timeout", 16'(n), 16'(3 * PER));
   endtask

   initial begin
      bus.selout = 1'b0; bus.op_a = '0; bus.op_b = '0;
      bus.result = '0; bus.res_valid = 1'b0;

      // Reset held, then one frame of dashes.
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      $display("reset released, expecting a dash frame");
      wait_phase(PER - 4);

      // Operands A/B.
      bus.selout = 1'b1; bus.op_a = 8'h3C; bus.op_b = 8'hA5;
      $display("show A=3c B=a5");
      wait_phase(PER - 4);
      wait_phase(PER - 4);

      // Valid result.
      bus.selout = 1'b0; bus.res_valid = 1'b1; bus.result = 16'hBEEF;
      $display("show result beef");
      wait_phase(PER - 4);
      wait_phase(PER - 4);

      // Mid-frame change stays hidden until the next boundary.
      bus.result = 16'h1234;
      $display("show result 1234, then 0000 mid-frame");
      wait_phase(PER / 2);
      wait_phase(PER / 2);
      bus.result = 16'h0000;
      wait_phase(PER - 4);
      wait_phase(PER - 4);

      // Random inputs changed at random phases, including exactly at the boundary edge.
      for (int f = 0; f < 24; f++) begin
         wait_phase((f % 4 == 0) ? PER - 1 : int'($urandom_range(0, PER - 1)));
         bus.selout    = 1'($urandom);
         bus.res_valid = 1'($urandom);
         bus.op_a      = 8'($urandom);
         bus.op_b      = 8'($urandom);
         bus.result    = 16'($urandom);
         $display("frame %0d: sel=%0d valid=%0d a=%h b=%h res=%h", f, bus.selout,
                  bus.res_valid, bus.op_a, bus.op_b, bus.result);
      end
      wait_phase(PER - 1);
      wait_phase(PER - 1);

      // Asynchronous reset in the middle of digit 2's active window.
      bus.selout = 1'b1; bus.op_a = 8'h77; bus.op_b = 8'h11;
      wait_phase(PER - 4);
      wait_phase(2 * PS + 4);
      chk_en = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("async_an", 16'(bus.an_n), 16'h000F);
      check("async_seg", 16'(bus.seg_n), 16'h00FF);
      chk_en = 1'b1;
      $display("async reset mid-slot");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rel_blank1", 16'(bus.an_n), 16'h000F);
      @(negedge clk);
      check("rel_blank2", 16'(bus.an_n), 16'h000F);
      @(negedge clk);
      check("rel_dig0_an", 16'(bus.an_n), 16'h000E);
      check("rel_dig0_seg", 16'(bus.seg_n), 16'h00BF);
      wait_phase(PER - 1);
      wait_phase(PER - 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
